// File: rtl/apu_pkg.sv
// Shared APU constants: frame-sequencer default step reloads and event masks.
package apu_pkg;

  localparam int APU_CNT_W = 12;
  localparam int APU_NSTEP = 5;

  typedef logic [APU_NSTEP-1:0] step_mask_t;
  typedef logic [APU_CNT_W-1:0] frame_cnt_t;

  localparam frame_cnt_t APU_LOAD [APU_NSTEP] =
    '{12'd3727, 12'd3727, 12'd3728, 12'd3728, 12'd3725};

  localparam step_mask_t APU_QMASK0 = 5'b01111;
  localparam step_mask_t APU_HMASK0 = 5'b01010;
  localparam step_mask_t APU_QMASK1 = 5'b10111;
  localparam step_mask_t APU_HMASK1 = 5'b10010;

endpackage

// File: rtl/apu_frame_seq.sv
// APU frame sequencer: tick-enabled step down-counter producing quarter/half-frame
// pulses and the frame interrupt flag, with restart on frame-control writes.
module apu_frame_seq
  import apu_pkg::*;
#(
  parameter int               CNT_W    = APU_CNT_W,
  parameter int               NSTEP    = APU_NSTEP,
  parameter int               STEPS0   = 4,
  parameter int               STEPS1   = 5,
  parameter logic [CNT_W-1:0] LOAD [NSTEP] = APU_LOAD,
  parameter logic [NSTEP-1:0] QMASK0   = APU_QMASK0,
  parameter logic [NSTEP-1:0] HMASK0   = APU_HMASK0,
  parameter logic [NSTEP-1:0] QMASK1   = APU_QMASK1,
  parameter logic [NSTEP-1:0] HMASK1   = APU_HMASK1,
  parameter int               IRQ_STEP = STEPS0 - 1
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     tick,
  input  logic                     wr,
  input  logic                     wr_mode,
  input  logic                     wr_inhibit,
  input  logic                     stat_rd,
  output logic                     qframe,
  output logic                     hframe,
  output logic                     irq_flag,
  output logic                     irq_n,
  output logic                     mode,
  output logic [$clog2(NSTEP)-1:0] step
);

  localparam int STEP_W = $clog2(NSTEP);
  localparam logic [STEP_W-1:0] LAST0    = STEP_W'(STEPS0 - 1);
  localparam logic [STEP_W-1:0] LAST1    = STEP_W'(STEPS1 - 1);
  localparam logic [STEP_W-1:0] IRQ_IDX  = STEP_W'(IRQ_STEP);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
  localparam logic [STEP_W-1:0] STEP_NIL = {STEP_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_NIL  = {CNT_W{1'b0}};

  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic [STEP_W-1:0] step_r, step_nxt_s, last_s;
  logic [NSTEP-1:0]  qmask_s, hmask_s;
  logic              mode_r, mode_nxt_s;
  logic              inhibit_r, inhibit_nxt_s;
  logic              pend_r, pend_nxt_s;
  logic              irq_r, irq_nxt_s;
  logic              q_r, q_nxt_s;
  logic              h_r, h_nxt_s;
  logic              expire_s, irq_set_s, irq_clr_s;

  // Next-state: restart beats expiry; a write only arms the restart for a later tick.
  always_comb begin
    cnt_nxt_s     = cnt_r;
    step_nxt_s    = step_r;
    mode_nxt_s    = mode_r;
    inhibit_nxt_s = inhibit_r;
    pend_nxt_s    = pend_r;
    irq_nxt_s     = irq_r;
    q_nxt_s       = 1'b0;
    h_nxt_s       = 1'b0;
    qmask_s       = mode_r ? QMASK1 : QMASK0;
    hmask_s       = mode_r ? HMASK1 : HMASK0;
    last_s        = mode_r ? LAST1  : LAST0;
    expire_s      = tick && !pend_r && (cnt_r == CNT_NIL);

    if (tick && pend_r) begin
      cnt_nxt_s  = LOAD[0];
      step_nxt_s = STEP_ONE;
      pend_nxt_s = 1'b0;
      q_nxt_s    = mode_r;
      h_nxt_s    = mode_r;
    end else if (expire_s) begin
      q_nxt_s   = qmask_s[step_r];
      h_nxt_s   = hmask_s[step_r];
      cnt_nxt_s = LOAD[step_r];
      // ">=" also catches a stale step left over from a longer mode
      if (step_r >= last_s) begin
        step_nxt_s = STEP_NIL;
      end else begin
        step_nxt_s = step_r + STEP_ONE;
      end
    end else if (tick) begin
      cnt_nxt_s = cnt_r - CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end

    if (wr) begin
      mode_nxt_s    = wr_mode;
      inhibit_nxt_s = wr_inhibit;
      pend_nxt_s    = 1'b1;
    end else begin
      mode_nxt_s    = mode_r;
      inhibit_nxt_s = inhibit_r;
    end

    irq_set_s = expire_s && !mode_r && !inhibit_r && (step_r == IRQ_IDX);
    irq_clr_s = stat_rd || inhibit_r || (wr && wr_inhibit);
    if (irq_set_s) begin
      irq_nxt_s = 1'b1;
    end else if (irq_clr_s) begin
      irq_nxt_s = 1'b0;
    end else begin
      irq_nxt_s = irq_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt_r     <= CNT_NIL;
      step_r    <= STEP_NIL;
      mode_r    <= 1'b0;
      inhibit_r <= 1'b0;
      pend_r    <= 1'b0;
      irq_r     <= 1'b0;
      q_r       <= 1'b0;
      h_r       <= 1'b0;
    end else begin
      cnt_r     <= cnt_nxt_s;
      step_r    <= step_nxt_s;
      mode_r    <= mode_nxt_s;
      inhibit_r <= inhibit_nxt_s;
      pend_r    <= pend_nxt_s;
      irq_r     <= irq_nxt_s;
      q_r       <= q_nxt_s;
      h_r       <= h_nxt_s;
    end
  end

  assign qframe   = q_r;
  assign hframe   = h_r;
  assign irq_flag = irq_r;
  assign irq_n    = ~irq_r;
  assign mode     = mode_r;
  assign step     = step_r;

endmodule
